// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_arbiter
// Purpose  : Round-robin arbiter sharing one register bank (2R/1W) between
//            the core datapath (requester 0) and the debug/loader port
//            (requester 1). Wen is registered, and writes to register 0
//            can be suppressed.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_arbiter #(
   parameter int DW           = 32,
   parameter int AWD          = 5,
   parameter int ZERO_PROTECT = 1
) (
   input  logic           clk,
   input  logic           rst,
   // requester 0 (core datapath)
   input  logic           Req0,
   input  logic           Wr0,
   input  logic [AWD-1:0] AR1_0,
   input  logic [AWD-1:0] AR2_0,
   input  logic [AWD-1:0] AW0,
   input  logic [DW-1:0]  Datow0,
   output logic           Gnt0,
   output logic           Done0,
   output logic [DW-1:0]  Dato1_0,
   output logic [DW-1:0]  Dato2_0,
   // requester 1 (debug/loader)
   input  logic           Req1,
   input  logic           Wr1,
   input  logic [AWD-1:0] AR1_1,
   input  logic [AWD-1:0] AR2_1,
   input  logic [AWD-1:0] AW1,
   input  logic [DW-1:0]  Datow1,
   output logic           Gnt1,
   output logic           Done1,
   output logic [DW-1:0]  Dato1_1,
   output logic [DW-1:0]  Dato2_1,
   // register bank side
   output logic [AWD-1:0] AR1,
   output logic [AWD-1:0] AR2,
   output logic [AWD-1:0] AW,
   output logic [DW-1:0]  Datow,
   output logic           Wen,
   input  logic [DW-1:0]  Dato1,
   input  logic [DW-1:0]  Dato2
);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_ACCESS = 2'd1;
   localparam logic [1:0] c_RESP   = 2'd2;

   logic [1:0]     r_state;
   logic [1:0]     w_next_state;
   logic           r_owner;
   logic           r_prio;
   logic           r_wen;
   logic [AWD-1:0] r_ar1;
   logic [AWD-1:0] r_ar2;
   logic [AWD-1:0] r_aw;
   logic [DW-1:0]  r_datow;
   logic [DW-1:0]  r_dato1_0;
   logic [DW-1:0]  r_dato2_0;
   logic [DW-1:0]  r_dato1_1;
   logic [DW-1:0]  r_dato2_1;

   logic           w_any_req;
   logic           w_winner;
   logic           w_sel_wr;
   logic [AWD-1:0] w_sel_ar1;
   logic [AWD-1:0] w_sel_ar2;
   logic [AWD-1:0] w_sel_aw;
   logic [DW-1:0]  w_sel_datow;
   logic           w_sel_wen;
   logic [DW-1:0]  w_rd1;
   logic [DW-1:0]  w_rd2;
   logic           w_gnt0;
   logic           w_gnt1;
   logic           w_done0;
   logic           w_done1;

   // Winner selection: on contention the priority pointer decides.
   always_comb begin
      w_any_req   = Req0 | Req1;
      w_winner    = (Req0 && Req1) ? r_prio : Req1;
      w_sel_wr    = w_winner ? Wr1    : Wr0;
      w_sel_ar1   = w_winner ? AR1_1  : AR1_0;
      w_sel_ar2   = w_winner ? AR2_1  : AR2_0;
      w_sel_aw    = w_winner ? AW1    : AW0;
      w_sel_datow = w_winner ? Datow1 : Datow0;
      // A protected address-0 write never raises Wen, so it is also never forwarded.
      w_sel_wen   = w_sel_wr && !((ZERO_PROTECT != 0) && (w_sel_aw == '0));
   end

   // Write-first forwarding so a same-address read returns the new data.
   always_comb begin
      w_rd1 = (r_wen && (r_ar1 == r_aw)) ? r_datow : Dato1;
      w_rd2 = (r_wen && (r_ar2 == r_aw)) ? r_datow : Dato2;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic: IDLE -> ACCESS -> RESP -> IDLE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:   if (w_any_req) w_next_state = c_ACCESS;
         c_ACCESS: w_next_state = c_RESP;
         c_RESP:   w_next_state = c_IDLE;
         default:  w_next_state = c_IDLE;
      endcase
   end

   // Output decode: grant spans ACCESS and RESP, done only RESP.
   always_comb begin
      w_gnt0  = 1'b0;
      w_gnt1  = 1'b0;
      w_done0 = 1'b0;
      w_done1 = 1'b0;
      if (r_state == c_ACCESS || r_state == c_RESP) begin
         w_gnt0 = !r_owner;
         w_gnt1 = r_owner;
      end
      if (r_state == c_RESP) begin
         w_done0 = !r_owner;
         w_done1 = r_owner;
      end
   end

   // Datapath: latch bank request on grant, capture read data, rotate priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner   <= 1'b0;
         r_prio    <= 1'b0;
         r_wen     <= 1'b0;
         r_ar1     <= '0;
         r_ar2     <= '0;
         r_aw      <= '0;
         r_datow   <= '0;
         r_dato1_0 <= '0;
         r_dato2_0 <= '0;
         r_dato1_1 <= '0;
         r_dato2_1 <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_any_req) begin
                  r_owner <= w_winner;
                  r_ar1   <= w_sel_ar1;
                  r_ar2   <= w_sel_ar2;
                  r_aw    <= w_sel_aw;
                  r_datow <= w_sel_datow;
                  r_wen   <= w_sel_wen;
               end
            end
            c_ACCESS: begin
               r_wen <= 1'b0;
               if (r_owner) begin
                  r_dato1_1 <= w_rd1;
                  r_dato2_1 <= w_rd2;
               end else begin
                  r_dato1_0 <= w_rd1;
                  r_dato2_0 <= w_rd2;
               end
            end
            c_RESP: begin
               r_prio <= ~r_owner;
            end
            default: begin
               r_wen <= 1'b0;
            end
         endcase
      end
   end

   assign Gnt0    = w_gnt0;
   assign Gnt1    = w_gnt1;
   assign Done0   = w_done0;
   assign Done1   = w_done1;
   assign Dato1_0 = r_dato1_0;
   assign Dato2_0 = r_dato2_0;
   assign Dato1_1 = r_dato1_1;
   assign Dato2_1 = r_dato2_1;
   assign AR1     = r_ar1;
   assign AR2     = r_ar2;
   assign AW      = r_aw;
   assign Datow   = r_datow;
   assign Wen     = r_wen;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_arbiter
// Purpose  : Directed self-checking bench for reg_bank_arbiter with a
//            behavioural register bank; a second instance has write
//            protection disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_arbiter;
   localparam int DW  = 32;
   localparam int AWD = 5;

   logic clk = 1'b0;
   logic rst;
   logic Req0, Wr0, Req1, Wr1;
   logic [AWD-1:0] AR1_0, AR2_0, AW0, AR1_1, AR2_1, AW1;
   logic [DW-1:0]  Datow0, Datow1;
   logic Gnt0, Done0, Gnt1, Done1;
   logic [DW-1:0]  Dato1_0, Dato2_0, Dato1_1, Dato2_1;
   logic [AWD-1:0] AR1, AR2, AW;
   logic [DW-1:0]  Datow, Dato1, Dato2;
   logic Wen;

   // second instance (ZERO_PROTECT=0), requester 0 shared, requester 1 idle
   logic p2_Gnt0, p2_Done0, p2_Gnt1, p2_Done1, p2_Wen;
   logic [DW-1:0]  p2_Dato1_0, p2_Dato2_0, p2_Dato1_1, p2_Dato2_1, p2_Datow;
   logic [AWD-1:0] p2_AR1, p2_AR2, p2_AW;
   logic           tie0    = 1'b0;
   logic [AWD-1:0] tie0_a  = '0;
   logic [DW-1:0]  tie0_d  = '0;

   // bank model
   logic [DW-1:0]  mem [0:31];
   logic           load_en;
   logic [AWD-1:0] load_addr;
   logic [DW-1:0]  load_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_bank_arbiter #(.DW(DW), .AWD(AWD), .ZERO_PROTECT(1)) dut (
      .clk(clk), .rst(rst),
      .Req0(Req0), .Wr0(Wr0), .AR1_0(AR1_0), .AR2_0(AR2_0), .AW0(AW0), .Datow0(Datow0),
      .Gnt0(Gnt0), .Done0(Done0), .Dato1_0(Dato1_0), .Dato2_0(Dato2_0),
      .Req1(Req1), .Wr1(Wr1), .AR1_1(AR1_1), .AR2_1(AR2_1), .AW1(AW1), .Datow1(Datow1),
      .Gnt1(Gnt1), .Done1(Done1), .Dato1_1(Dato1_1), .Dato2_1(Dato2_1),
      .AR1(AR1), .AR2(AR2), .AW(AW), .Datow(Datow), .Wen(Wen),
      .Dato1(Dato1), .Dato2(Dato2)
   );

   reg_bank_arbiter #(.DW(DW), .AWD(AWD), .ZERO_PROTECT(0)) dut_np (
      .clk(clk), .rst(rst),
      .Req0(Req0), .Wr0(Wr0), .AR1_0(AR1_0), .AR2_0(AR2_0), .AW0(AW0), .Datow0(Datow0),
      .Gnt0(p2_Gnt0), .Done0(p2_Done0), .Dato1_0(p2_Dato1_0), .Dato2_0(p2_Dato2_0),
      .Req1(tie0), .Wr1(tie0), .AR1_1(tie0_a), .AR2_1(tie0_a), .AW1(tie0_a), .Datow1(tie0_d),
      .Gnt1(p2_Gnt1), .Done1(p2_Done1), .Dato1_1(p2_Dato1_1), .Dato2_1(p2_Dato2_1),
      .AR1(p2_AR1), .AR2(p2_AR2), .AW(p2_AW), .Datow(p2_Datow), .Wen(p2_Wen),
      .Dato1(tie0_d), .Dato2(tie0_d)
   );

   // Register bank: combinational read, write while Wen is high at the edge.
   always @(posedge clk) begin
      if (load_en)  mem[load_addr] <= load_data;
      else if (Wen) mem[AW] <= Datow;
   end
   assign Dato1 = mem[AR1];
   assign Dato2 = mem[AR2];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int  n_done, overlap, spacing_err, wen1_cnt, wen2_cnt, done_seen;
   logic [AWD-1:0] p2_aw_seen;
   logic [1:0] order [0:3];
   int  when [0:3];

   initial begin
      rst = 1'b1;
      Req0 = 0; Wr0 = 0; AR1_0 = '0; AR2_0 = '0; AW0 = '0; Datow0 = '0;
      Req1 = 0; Wr1 = 0; AR1_1 = '0; AR2_1 = '0; AW1 = '0; Datow1 = '0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      for (int i = 0; i < 32; i++) mem[i] = '0;

      // preload bank while reset is held
      @(negedge clk);
      load_en = 1'b1; load_addr = 5'd5; load_data = 32'd10;
      @(negedge clk);
      load_addr = 5'd6; load_data = 32'd15;
      @(negedge clk);
      load_en = 1'b0;
      rst = 1'b0;

      // reset state
      check_val("rst_gnt0",  32'(Gnt0), 0);
      check_val("rst_gnt1",  32'(Gnt1), 0);
      check_val("rst_wen",   32'(Wen), 0);
      check_val("rst_done0", 32'(Done0), 0);
      check_val("rst_dato",  Dato1_0, 0);
      check_val("rst_ar1",   32'(AR1), 0);

      // plain read by requester 0
      Req0 = 1; Wr0 = 0; AR1_0 = 5'd5; AR2_0 = 5'd6;
      @(negedge clk);
      check_val("t1_gnt0_acc", 32'(Gnt0), 1);
      check_val("t1_wen_acc",  32'(Wen), 0);
      check_val("t1_done_acc", 32'(Done0), 0);
      check_val("t1_ar1",      32'(AR1), 5);
      @(negedge clk);
      check_val("t1_done",  32'(Done0), 1);
      check_val("t1_gnt0",  32'(Gnt0), 1);
      check_val("t1_dato1", Dato1_0, 10);
      check_val("t1_dato2", Dato2_0, 15);
      Req0 = 0;
      @(negedge clk);
      check_val("t1_idle_gnt",  32'(Gnt0), 0);
      check_val("t1_idle_done", 32'(Done0), 0);

      // write with forwarding by requester 1
      Req1 = 1; Wr1 = 1; AW1 = 5'd7; Datow1 = 32'hDEAD_BEEF; AR1_1 = 5'd7; AR2_1 = 5'd5;
      @(negedge clk);
      check_val("t2_gnt1",  32'(Gnt1), 1);
      check_val("t2_wen",   32'(Wen), 1);
      check_val("t2_aw",    32'(AW), 7);
      check_val("t2_datow", Datow, 32'hDEAD_BEEF);
      @(negedge clk);
      check_val("t2_done1",   32'(Done1), 1);
      check_val("t2_wen_off", 32'(Wen), 0);
      check_val("t2_fwd",     Dato1_1, 32'hDEAD_BEEF);
      check_val("t2_dato2",   Dato2_1, 10);
      check_val("t2_hold0",   Dato1_0, 10);
      Req1 = 0; Wr1 = 0;
      @(negedge clk);
      Req0 = 1; AR1_0 = 5'd7; AR2_0 = 5'd0;
      @(negedge clk);
      @(negedge clk);
      check_val("t2_rb_done", 32'(Done0), 1);
      check_val("t2_readback", Dato1_0, 32'hDEAD_BEEF);
      Req0 = 0;
      @(negedge clk);

      // fairness with both requests held
      do_reset();
      Req0 = 1; Req1 = 1; AR1_0 = 5'd5; AR1_1 = 5'd6;
      n_done = 0; overlap = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (Gnt0 && Gnt1) overlap++;
         if ((Done0 || Done1) && n_done < 4) begin
            order[n_done] = {1'b0, Done1};
            when[n_done]  = i;
            n_done++;
         end
      end
      Req0 = 0; Req1 = 0;
      check_val("t3_ndone", 32'(n_done), 4);
      check_val("t3_ord0", 32'(order[0]), 0);
      check_val("t3_ord1", 32'(order[1]), 1);
      check_val("t3_ord2", 32'(order[2]), 0);
      check_val("t3_ord3", 32'(order[3]), 1);
      check_val("t3_first_done", 32'(when[0]), 1);
      spacing_err = 0;
      for (int k = 1; k < 4; k++) if (when[k] - when[k-1] != 3) spacing_err++;
      check_val("t3_spacing", 32'(spacing_err), 0);
      check_val("t3_overlap", 32'(overlap), 0);

      // protected address-0 write, and unprotected instance
      do_reset();
      Req0 = 1; Wr0 = 1; AW0 = 5'd0; Datow0 = 32'd99;
      wen1_cnt = 0; wen2_cnt = 0; done_seen = 0; p2_aw_seen = 5'h1f;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wen1_cnt += int'(Wen);
         wen2_cnt += int'(p2_Wen);
         if (Done0) done_seen = 1;
         if (p2_Wen) p2_aw_seen = p2_AW;
      end
      Req0 = 0; Wr0 = 0;
      check_val("t4_wen_prot",   32'(wen1_cnt), 0);
      check_val("t4_done0",      32'(done_seen), 1);
      check_val("t4_wen_noprot", 32'(wen2_cnt), 1);
      check_val("t4_aw_noprot",  32'(p2_aw_seen), 0);

      // request dropped and inputs changed during ACCESS
      do_reset();
      Req0 = 1; Wr0 = 0; AR1_0 = 5'd5; AR2_0 = 5'd6;
      @(negedge clk);
      check_val("t5_gnt0", 32'(Gnt0), 1);
      Req0 = 0; AR1_0 = 5'd6;
      @(negedge clk);
      check_val("t5_done0", 32'(Done0), 1);
      check_val("t5_dato1", Dato1_0, 10);
      @(negedge clk);
      check_val("t5_idle", 32'(Gnt0), 0);
      Req0 = 1; Req1 = 1; Wr1 = 0; AR1_1 = 5'd5;
      @(negedge clk);
      check_val("t5_prio_gnt1", 32'(Gnt1), 1);
      check_val("t5_prio_gnt0", 32'(Gnt0), 0);
      Req0 = 0;
      @(negedge clk);
      check_val("t5_done1", 32'(Done1), 1);
      Req1 = 0;
      @(negedge clk);

      // reset in the middle of a write access
      Req0 = 1; Wr0 = 1; AW0 = 5'd3; Datow0 = 32'd5;
      @(negedge clk);
      check_val("t6_wen_pre", 32'(Wen), 1);
      check_val("t6_gnt_pre", 32'(Gnt0), 1);
      #2 rst = 1'b1;
      #1;
      check_val("t6_wen_rst",  32'(Wen), 0);
      check_val("t6_gnt_rst",  32'(Gnt0), 0);
      check_val("t6_done_rst", 32'(Done0), 0);
      check_val("t6_dato_rst", Dato1_0, 0);
      Req0 = 0; Wr0 = 0;
      @(negedge clk);
      rst = 1'b0;
      Req1 = 1; Wr1 = 0; AR1_1 = 5'd5; AR2_1 = 5'd6;
      @(negedge clk);
      check_val("t6_gnt1", 32'(Gnt1), 1);
      @(negedge clk);
      check_val("t6_done1", 32'(Done1), 1);
      check_val("t6_dato1", Dato1_1, 10);
      check_val("t6_dato2", Dato2_1, 15);
      Req1 = 0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares the single register bank (two read ports, one write port, combinational, level-sensitive Wen) between two requesters.
- Requester 0 is the core datapath; requester 1 is the debug/loader port.
- Each transaction is a req/done handshake: one bank access of up to two reads plus an optional write.
- Arbitration is round-robin. Wen is registered and glitch-free, and writes to register 0 are protected.

Parameters:
- DW, 32, data width of bank entries.
- AWD, 5, register address width.
- ZERO_PROTECT, 1, when 1 any write to address 0 is suppressed (Wen held low).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Req0  in  1  requester 0 transaction request; held high until Done0.
- Wr0  in  1  requester 0 write enable for this transaction.
- AR1_0  in  AWD  requester 0 read address 1.
- AR2_0  in  AWD  requester 0 read address 2.
- AW0  in  AWD  requester 0 write address.
- Datow0  in  DW  requester 0 write data.
- Gnt0  out  1  requester 0 owns the bank (ACCESS or RESP).
- Done0  out  1  one-cycle pulse; Dato1_0/Dato2_0 are valid.
- Dato1_0  out  DW  requester 0 read data 1 (registered).
- Dato2_0  out  DW  requester 0 read data 2 (registered).
- Req1, Wr1, AR1_1, AR2_1, AW1, Datow1, Gnt1, Done1, Dato1_1, Dato2_1: identical set for requester 1.
- AR1  out  AWD  bank read address 1.
- AR2  out  AWD  bank read address 2.
- AW  out  AWD  bank write address.
- Datow  out  DW  bank write data.
- Wen  out  1  bank write enable (registered).
- Dato1  in  DW  bank read data 1.
- Dato2  in  DW  bank read data 2.

Behaviour:
- Reset values (async, immediate):
  - state=IDLE, owner=0, prio=0.
  - Wen=0, AR1=AR2=AW=0, Datow=0.
  - Gnt0/1=0, Done0/1=0, all Dato*_* = 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, any Req high at clock edge:
  - Pick winner: if both requests are high, winner=prio, else the single requester.
  - Latch winner's AR1/AR2/AW/Datow onto the bank ports.
  - Set Wen = Wr & ~(ZERO_PROTECT & AW==0).
  - Assert that requester's Gnt; go to ACCESS.
- ACCESS (exactly one cycle):
  - Bank ports stable, Wen as latched.
  - At the edge: capture read data into owner's Dato1_x/Dato2_x, clear Wen, go to RESP.
- Read forwarding: if Wen was high and ARn==AW, capture Datow instead of Dato n (write-first result is deterministic). Protected address-0 writes are not forwarded.
- RESP (one cycle):
  - Done_owner=1, Gnt_owner stays 1.
  - At the edge: Done and Gnt clear, prio=~owner, go to IDLE.
- Latency:
  - Req sampled at edge N; Gnt high from N; Wen high during cycle N+1 only.
  - Done high during cycle N+2.
  - Earliest next grant at edge N+3, giving one transaction per 3 cycles.
- Fairness: two continuously asserted requests alternate grants (0,1,0,1...). prio flips only after a completed transaction.
- Req drop mid-transaction: the transaction still completes and Done still pulses. Requester inputs are ignored after the grant edge.
- Request inputs are sampled only in IDLE; changes in ACCESS/RESP have no effect.
- Non-owner Dato*_* outputs hold their previous values.
- Wen is never high outside ACCESS and is never high for more than one consecutive cycle.
- Reset mid-ACCESS: Wen drops asynchronously. Whether that write landed is undefined; the requester must retry.
- Gnt0 and Gnt1 are never both high.

Test Plan:
- Reset, then Req0 read AR1_0=5, AR2_0=6, Wr0=0 (bank holds 10/15): Gnt0 at N, Wen stays 0, Done0 at N+2 with Dato1_0=10, Dato2_0=15.
- Req1 Wr1=1, AW1=7, Datow1=32'hDEAD_BEEF, AR1_1=7: Wen=1 only in cycle N+1 with AW=7. Dato1_1=32'hDEAD_BEEF. A later read of 7 returns 32'hDEAD_BEEF.
- Req0 and Req1 both held high for 4 transactions from reset: grant order 0,1,0,1. Done pulses 3 cycles apart. Gnt0 and Gnt1 never overlap.
- Req0 Wr0=1, AW0=0, Datow0=99, ZERO_PROTECT=1: Wen never asserts and Done0 still pulses. With ZERO_PROTECT=0, Wen=1 for one cycle.
- Req0 dropped during ACCESS: Done0 still pulses at N+2, and the FSM returns to IDLE with prio=1.
- rst asserted mid-ACCESS with Wen=1: Wen, Gnt and Done all go to 0 before the next edge. After release, a new Req1 is granted normally.
